// File: rtl/t03_mmio_router.sv
// t03_mmio_router: decodes single-word CPU load/store requests onto N_CH
// req/ack peripheral channels (with a bounded ack timeout) or onto a local
// bank of REG_DEPTH 32-bit registers. All outputs come from flops.
module t03_mmio_router #(
    parameter int N_CH      = 4,
    parameter int REG_DEPTH = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_din,
    input  logic                    cpu_wen,
    input  logic                    cpu_ren,
    output logic [31:0]             cpu_do,
    output logic                    cpu_ack,
    output logic                    cpu_err,
    output logic                    busy,
    output logic [N_CH-1:0]         ch_req,
    output logic                    ch_we,
    output logic [23:0]             ch_addr,
    output logic [31:0]             ch_dout,
    input  logic [N_CH*32-1:0]      ch_din,
    input  logic [N_CH-1:0]         ch_ack,
    output logic [REG_DEPTH*32-1:0] reg_q,
    output logic [REG_DEPTH-1:0]    reg_wr
);

    localparam int AW = $clog2(REG_DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOCAL, WAIT, RESP} state_t;

    state_t          state_reg;
    state_t          state_next;

    logic            req_valid;
    logic            is_local;
    logic            is_chan;
    logic            ack_hit;
    logic            timeout_hit;
    logic [N_CH-1:0] ch_onehot;
    logic [31:0]     ch_rdata;
    logic [31:0]     regs_reg [REG_DEPTH];
    logic [AW-1:0]   reg_sel_reg;
    logic [31:0]     wdata_reg;
    logic            we_reg;
    logic [CW-1:0]   cnt_reg;
    logic            unused_addr;

    // Word-aligned addresses: the byte offset bits carry no information.
    assign unused_addr = ^cpu_addr[1:0];

    // Address decode; only consulted while IDLE.
    assign req_valid = cpu_wen | cpu_ren;
    assign is_chan   = (cpu_addr[31:28] == 4'h3) && ({1'b0, cpu_addr[27:24]} < 5'(N_CH));
    assign is_local  = (cpu_addr[31:28] == 4'hF) && (cpu_addr[27:AW+2] == '0);

    // ch_req is one-hot on the active channel, so it doubles as the ack/data select.
    assign ack_hit     = |(ch_ack & ch_req);
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
    assign busy        = (state_reg != IDLE);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign ch_onehot[gi] = (cpu_addr[27:24] == 4'(gi));
        end
        for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_regq
            assign reg_q[gi*32 +: 32] = regs_reg[gi];
        end
    endgenerate

    // Read-data select for the channel currently being requested.
    always_comb begin
        ch_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_req[i]) begin
                ch_rdata = ch_rdata | ch_din[i*32 +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: ack beats timeout when both land in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (is_local) begin
                        state_next = LOCAL;
                    end else if (is_chan) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            LOCAL:   state_next = RESP;
            WAIT:    if (ack_hit || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction datapath: latches the request, drives the channel and
    // produces the one-cycle CPU response on entry to RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_do      <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            ch_req      <= '0;
            ch_we       <= 1'b0;
            ch_addr     <= '0;
            ch_dout     <= '0;
            reg_wr      <= '0;
            reg_sel_reg <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            reg_wr  <= '0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg      <= cpu_wen;
                        wdata_reg   <= cpu_din;
                        reg_sel_reg <= cpu_addr[AW+1:2];
                        if (is_chan) begin
                            ch_req  <= ch_onehot;
                            ch_we   <= cpu_wen;
                            ch_addr <= cpu_addr[23:0];
                            ch_dout <= cpu_din;
                            cnt_reg <= '0;
                        end else if (!is_local) begin
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
                            if (!cpu_wen) cpu_do <= '0;
                        end
                    end
                end
                LOCAL: begin
                    cpu_ack <= 1'b1;
                    if (we_reg) begin
                        reg_wr[reg_sel_reg] <= 1'b1;
                    end else begin
                        cpu_do <= regs_reg[reg_sel_reg];
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        ch_req  <= '0;
                        cpu_ack <= 1'b1;
                        if (!we_reg) cpu_do <= ch_rdata;
                    end else if (timeout_hit) begin
                        ch_req  <= '0;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b1;
                        if (!we_reg) cpu_do <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Local register bank, written in the LOCAL cycle of a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < REG_DEPTH; k++) begin
                regs_reg[k] <= '0;
            end
        end else if (state_reg == LOCAL && we_reg) begin
            regs_reg[reg_sel_reg] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_t03_mmio_router.sv
// Bench for t03_mmio_router: directed transactions with a scoreboard of
// expected responses (error flag, read data, acknowledge edge) checked by a
// monitor whenever cpu_ack is seen.
module tb_t03_mmio_router;

    localparam int N_CH      = 4;
    localparam int REG_DEPTH = 8;
    localparam int TIMEOUT   = 255;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             cpu_addr;
    logic [31:0]             cpu_din;
    logic                    cpu_wen;
    logic                    cpu_ren;
    logic [31:0]             cpu_do;
    logic                    cpu_ack;
    logic                    cpu_err;
    logic                    busy;
    logic [N_CH-1:0]         ch_req;
    logic                    ch_we;
    logic [23:0]             ch_addr;
    logic [31:0]             ch_dout;
    logic [N_CH*32-1:0]      ch_din;
    logic [N_CH-1:0]         ch_ack;
    logic [REG_DEPTH*32-1:0] reg_q;
    logic [REG_DEPTH-1:0]    reg_wr;

    t03_mmio_router #(.N_CH(N_CH), .REG_DEPTH(REG_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
        .cpu_do(cpu_do), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .busy(busy),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_dout(ch_dout),
        .ch_din(ch_din), .ch_ack(ch_ack), .reg_q(reg_q), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_do = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_do"},    cpu_do, 32'h0);
        chk({tag, "_flags"}, 32'({cpu_ack, cpu_err, busy, ch_we}), 32'h0);
        chk({tag, "_req"},   32'(ch_req), 32'h0);
        chk({tag, "_addr"},  32'(ch_addr), 32'h0);
        chk({tag, "_dout"},  ch_dout, 32'h0);
        chk({tag, "_regq"},  32'(|reg_q), 32'h0);
        chk({tag, "_regwr"}, 32'(reg_wr), 32'h0);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        @(negedge clk);
        cpu_addr = a;
        cpu_din  = d;
        cpu_wen  = w;
        cpu_ren  = r;
    endtask

    // Drives a request and queues its expected response; e is the sampling edge.
    task automatic start_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic r, input int lat,
                             input logic [31:0] exp_data, input logic exp_err, output int e);
        exp_t x;
        drive_req(a, d, w, r);
        e        = cyc + 1;
        x.tag    = tag;
        x.data   = exp_data;
        x.err    = exp_err;
        x.edge_n = e + lat;
        sb.push_back(x);
    endtask

    // Waits (bounded) for cpu_ack at a falling edge, then drops the request.
    task automatic wait_ack(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1'b1;
        end
        if (!seen) chk({tag, "_ack_wait"}, 32'h0, 32'h1);
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && cpu_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'h1, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_err"}, 32'(cpu_err), 32'(mon_e.err));
                chk({mon_e.tag, "_do"},  cpu_do, mon_e.data);
                chk({mon_e.tag, "_lat"}, 32'(cyc + 1), 32'(mon_e.edge_n));
                $display("txn %-12s err=%0b do=%08h ack_edge=%0d", mon_e.tag, cpu_err, cpu_do, cyc + 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int cnt;
        bit seen;

        rst      = 1'b1;
        cpu_addr = '0;
        cpu_din  = '0;
        cpu_wen  = 1'b0;
        cpu_ren  = 1'b0;
        ch_din   = '0;
        ch_ack   = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("por");
        rst = 1'b0;

        // Reset while waiting on channel 1
        drive_req(32'h3100_0000, 32'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("midwait_req", 32'(ch_req), 32'h2);
        chk("midwait_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        cpu_ren = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_after");

        // Local write then read back
        start_req("loc_wr", 32'hF000_0008, 32'hCAFE_0001, 1'b1, 1'b0, 2, model_do, 1'b0, e);
        wait_ack("loc_wr", 10);
        chk("loc_wr_strobe", 32'(reg_wr), 32'h04);
        chk("loc_wr_regq", reg_q[95:64], 32'hCAFE_0001);
        @(negedge clk);
        chk("loc_wr_strobe_end", 32'(reg_wr), 32'h0);
        model_do = 32'hCAFE_0001;
        start_req("loc_rd", 32'hF000_0008, 32'h0, 1'b0, 1'b1, 2, model_do, 1'b0, e);
        wait_ack("loc_rd", 10);

        // Write and read both high: treated as a write, cpu_do unchanged
        start_req("both_wr", 32'hF000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2, model_do, 1'b0, e);
        wait_ack("both_wr", 10);
        chk("both_strobe", 32'(reg_wr), 32'h01);
        chk("both_regq0", reg_q[31:0], 32'hDEAD_BEEF);
        chk("both_regq2", reg_q[95:64], 32'hCAFE_0001);

        // Channel 2 read with a stray ack on channel 0
        model_do = 32'h1234_5678;
        start_req("ch_rd", 32'h3200_0010, 32'h0, 1'b0, 1'b1, 4, model_do, 1'b0, e);
        @(negedge clk);
        chk("ch_rd_req", 32'(ch_req), 32'h4);
        chk("ch_rd_addr", 32'(ch_addr), 32'h10);
        chk("ch_rd_we", 32'(ch_we), 32'h0);
        ch_ack = 4'b0001;
        @(negedge clk);
        ch_ack = 4'b0000;
        @(negedge clk);
        chk("ch_rd_stray", 32'(ch_req), 32'h4);
        ch_din[95:64] = 32'h1234_5678;
        ch_ack = 4'b0100;
        wait_ack("ch_rd", 10);
        ch_ack = 4'b0000;
        chk("ch_rd_req_drop", 32'(ch_req), 32'h0);

        // Channel 2 write timing out
        start_req("ch_to", 32'h3200_0000, 32'h5555_AAAA, 1'b1, 1'b0, TIMEOUT + 1, model_do, 1'b1, e);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 50 && !seen; i++) begin
            @(negedge clk);
            if (ch_req[2]) cnt++;
            if (cpu_ack) seen = 1'b1;
        end
        cpu_wen = 1'b0;
        chk("ch_to_seen", 32'(seen), 32'h1);
        chk("ch_to_req_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("ch_to_dout", ch_dout, 32'h5555_AAAA);
        chk("ch_to_we", 32'(ch_we), 32'h1);

        // Decode errors: bad local offset, bad channel, bad region
        model_do = 32'h0;
        start_req("dec_loc", 32'hF000_0100, 32'h0, 1'b0, 1'b1, 1, model_do, 1'b1, e);
        wait_ack("dec_loc", 10);
        model_do = 32'hCAFE_0001;
        start_req("loc_rd2", 32'hF000_0008, 32'h0, 1'b0, 1'b1, 2, model_do, 1'b0, e);
        wait_ack("loc_rd2", 10);
        model_do = 32'h0;
        start_req("dec_ch5", 32'h3500_0000, 32'h0, 1'b0, 1'b1, 1, model_do, 1'b1, e);
        wait_ack("dec_ch5", 10);
        chk("dec_ch5_req", 32'(ch_req), 32'h0);
        model_do = 32'hDEAD_BEEF;
        start_req("loc_rd0", 32'hF000_0000, 32'h0, 1'b0, 1'b1, 2, model_do, 1'b0, e);
        wait_ack("loc_rd0", 10);
        model_do = 32'h0;
        start_req("dec_reg1", 32'h1000_0000, 32'h0, 1'b0, 1'b1, 1, model_do, 1'b1, e);
        wait_ack("dec_reg1", 10);
        chk("dec_reg1_req", 32'(ch_req), 32'h0);

        // Ack on channel 1 in the same cycle as the timeout: ack wins
        model_do = 32'hA5A5_0F0F;
        ch_din[63:32] = 32'hA5A5_0F0F;
        start_req("ch_coinc", 32'h3100_0004, 32'h0, 1'b0, 1'b1, TIMEOUT + 1, model_do, 1'b0, e);
        while (cyc < e + TIMEOUT - 1) @(negedge clk);
        ch_ack = 4'b0010;
        wait_ack("ch_coinc", 10);
        ch_ack = 4'b0000;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/t03_mmio_router.md
# t03_mmio_router

Parametrised successor to the team's fixed-map MMIO front end. It accepts single-word CPU load/store requests and decodes them into one of N_CH external peripheral channels or a local register bank. External channels use a req/ack handshake with a bounded timeout; the local register bank drives the display/game-state registers. The block sits between the CPU data port and the peripherals (NES controller, wishbone manager, hardware counter, ...), replacing hard-wired per-peripheral muxing.

## Interface
Parameters:
- N_CH, 4, number of external channels (1..16)
- REG_DEPTH, 8, number of 32-bit local registers (power of two, 2..64)
- TIMEOUT, 255, maximum cycles spent waiting for a channel ack (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- cpu_addr  in  32  byte address, word aligned
- cpu_din  in  32  write data
- cpu_wen  in  1  write request, level
- cpu_ren  in  1  read request, level
- cpu_do  out  32  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  high with cpu_ack on decode error or timeout
- busy  out  1  high whenever the FSM is not IDLE
- ch_req  out  N_CH  one-hot channel request, held until ack or timeout
- ch_we  out  1  1 = write, 0 = read, for the active channel
- ch_addr  out  24  cpu_addr[23:0] of the active transaction
- ch_dout  out  32  write data to the active channel
- ch_din  in  N_CH*32  channel read data, channel i at bits [32i+31:32i]
- ch_ack  in  N_CH  channel completion, one bit per channel
- reg_q  out  REG_DEPTH*32  local register contents, register j at bits [32j+31:32j]
- reg_wr  out  REG_DEPTH  one-cycle strobe for the local register just written

## Operation
- Decode on cpu_addr[31:28]:
  - 4'h3: channel idx = cpu_addr[27:24]; idx ≥ N_CH is a decode error.
  - 4'hF: local register j = cpu_addr[log2(REG_DEPTH)+1:2]; nonzero cpu_addr[27:log2(REG_DEPTH)+2] is a decode error.
  - Anything else is a decode error.
- FSM states: IDLE, LOCAL, WAIT, RESP.
- IDLE: if cpu_wen|cpu_ren, latch addr, data and op. If both are high, the operation is a write. Next state:
  - local register → LOCAL
  - valid channel → WAIT, with ch_req[idx]=1 registered
  - decode error → RESP with err
- LOCAL:
  - Write: update register j and pulse reg_wr[j].
  - Read: capture register j into cpu_do.
  - Next state: RESP.
- WAIT:
  - Timeout counter is cleared on entry and increments every WAIT cycle.
  - ch_ack[idx]=1: on a read capture ch_din[idx] into cpu_do; drop ch_req; go to RESP, no error.
  - Counter reaches TIMEOUT-1 without ack: drop ch_req; go to RESP with err. On a read, cpu_do=0.
  - ch_ack on non-selected channels is ignored.
  - If ack and timeout coincide, ack wins.
- RESP: cpu_ack=1 and cpu_err=latched err for exactly one cycle, then IDLE.
- The CPU must drop wen/ren in the cycle after cpu_ack. A request still high in IDLE starts a new transaction.
- Requests are only sampled in IDLE. Changes to cpu_* during a transaction are ignored.
- cpu_do holds its value between reads. A write never changes cpu_do. A read that ends in decode error sets cpu_do=0.

## Timing
- Reset values: all outputs 0, all local registers 0, FSM IDLE, counter 0. Asserting rst mid-transaction drops ch_req immediately; no ack is generated.
- Latency is counted in clock edges from the edge E that samples the request in IDLE:
  - Decode error: cpu_ack high after E+1.
  - Local access: cpu_ack high after E+2. reg_q and reg_wr update at edge E+2, concurrent with cpu_ack.
  - Channel access: ch_req high after E+1. If ch_ack is sampled at edge M, ch_req falls and cpu_ack rises after edge M.
  - Timeout: ch_req is high for exactly TIMEOUT cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Minimum back-to-back local transaction period: 3 cycles.

## Test plan
- Reset mid-WAIT on channel 1: all outputs read 0 during and after reset; the next request is accepted normally.
- Write 32'hCAFE_0001 to 0xF000_0008, then read the same address → reg_wr=8'b0000_0100 for one cycle, reg_q[95:64]=32'hCAFE_0001, read returns 32'hCAFE_0001 with cpu_err=0; each cpu_ack comes 2 edges after request sampling.
- Read 0x3200_0010 with ch_ack[2] returned 3 cycles after ch_req[2] and ch_din[2]=32'h1234_5678 → ch_addr=24'h000010, ch_we=0, cpu_do=32'h1234_5678, cpu_ack one cycle after ch_ack; a stray ch_ack[0] during WAIT is ignored.
- Write to 0x3200_0000 with no ch_ack, using TIMEOUT=255 → ch_req[2] high for exactly 255 cycles, then cpu_ack=1 and cpu_err=1; cpu_do is unchanged.
- Read 0x3500_0000 (N_CH=4), then read 0x1000_0000 → each gives cpu_ack with cpu_err=1 and cpu_do=0 one edge after sampling; no ch_req asserted.
- cpu_wen and cpu_ren both high on 0xF000_0000 → treated as a write. With ch_ack[idx] arriving in the same cycle as the timeout → cpu_err=0.
